// File: rtl/clk_phase_meter.sv
// ---------------------------------------------------------------------------
// clk_phase_meter
//
// Measures the period of a sampled square wave (sig_a) and the lag of a
// second square wave (sig_b) behind it, both in system-clock cycles. Results
// are averaged over 2^AVG_LOG2 consecutive sig_a periods.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset_n      synchronous reset, active low
//   enable       high = measure, low = abort and return to idle
//   sig_a        asynchronous reference square wave
//   sig_b        asynchronous square wave whose lag is measured
//   period_out   averaged sig_a period (cycles)
//   lag_out      averaged sig_a-rise to sig_b-rise delay (cycles)
//   result_valid one-cycle pulse when period_out/lag_out update
//   lag_valid    qualifies lag_out (every period in the window saw a sig_b rise)
//   timeout      sticky while in FAULT: no sig_a rise for 2^CNT_W-1 cycles
//   busy         high in ARM and MEASURE
//   dbg_state    current FSM state (IDLE=0, ARM=1, MEASURE=2, FAULT=3)
//
// Handshake: result_valid is a plain strobe with no back-pressure; the
// result registers hold their value until the next strobe.
// ---------------------------------------------------------------------------
module clk_phase_meter #(
    parameter int CNT_W       = 16,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_a,
    input  logic             sig_b,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] lag_out,
    output logic             result_valid,
    output logic             lag_valid,
    output logic             timeout,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_FAULT   = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning: identical synchronizer + edge-detect depth on
    // both inputs, so the measured lag is not skewed by the pipeline.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   edge_a_q, edge_b_q;
    logic                   rise_a, rise_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            edge_a_q <= 1'b0;
            edge_b_q <= 1'b0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], sig_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], sig_b};
            edge_a_q <= sync_a_q[SYNC_STAGES-1];
            edge_b_q <= sync_b_q[SYNC_STAGES-1];
        end
    end

    assign rise_a = sync_a_q[SYNC_STAGES-1] & ~edge_a_q;
    assign rise_b = sync_b_q[SYNC_STAGES-1] & ~edge_b_q;

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lag_q, lag_d;
    logic             b_seen_q, b_seen_d;
    logic             miss_q, miss_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] psum_q, psum_d;
    logic [ACC_W-1:0] lsum_q, lsum_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] lag_out_q, lag_out_d;
    logic             lag_valid_q, lag_valid_d;
    logic             rv_q, rv_d;

    // Sums including the period being closed this cycle.
    logic [ACC_W-1:0] psum_close, lsum_close;
    logic             miss_close;

    assign psum_close = psum_q + ACC_W'(cnt_q);
    assign lsum_close = lsum_q + ACC_W'(lag_q);
    assign miss_close = miss_q | ~b_seen_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lag_d       = lag_q;
        b_seen_d    = b_seen_q;
        miss_d      = miss_q;
        idx_d       = idx_q;
        psum_d      = psum_q;
        lsum_d      = lsum_q;
        period_d    = period_q;
        lag_out_d   = lag_out_q;
        lag_valid_d = lag_valid_q;
        rv_d        = 1'b0;

        if (!enable) begin
            // Abort: partial window is dropped (ARM re-clears it), results held.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARM;
                    // ARM's first cycle counts as cycle 1 of the timeout span.
                    cnt_d   = CNT_W'(1);
                end

                S_ARM: begin
                    if (rise_a) begin
                        state_d  = S_MEASURE;
                        cnt_d    = CNT_W'(1);
                        psum_d   = '0;
                        lsum_d   = '0;
                        idx_d    = '0;
                        miss_d   = 1'b0;
                        // A sig_b rise coincident with the opening edge is lag 0.
                        b_seen_d = rise_b;
                        lag_d    = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_MEASURE: begin
                    if (rise_a) begin
                        // Close current period; the same edge opens the next one.
                        if (idx_q == IDX_LAST) begin
                            period_d    = psum_close[AVG_LOG2 +: CNT_W];
                            lag_out_d   = lsum_close[AVG_LOG2 +: CNT_W];
                            lag_valid_d = ~miss_close;
                            rv_d        = 1'b1;
                            psum_d      = '0;
                            lsum_d      = '0;
                            miss_d      = 1'b0;
                            idx_d       = '0;
                        end else begin
                            psum_d = psum_close;
                            lsum_d = lsum_close;
                            miss_d = miss_close;
                            idx_d  = idx_q + IDX_W'(1);
                        end
                        cnt_d    = CNT_W'(1);
                        // Coincident sig_b rise belongs to the new period only.
                        b_seen_d = rise_b;
                        lag_d    = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (rise_b && !b_seen_q) begin
                            b_seen_d = 1'b1;
                            lag_d    = cnt_q;
                        end
                    end
                end

                S_FAULT: begin
                    state_d = S_FAULT;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lag_q       <= '0;
            b_seen_q    <= 1'b0;
            miss_q      <= 1'b0;
            idx_q       <= '0;
            psum_q      <= '0;
            lsum_q      <= '0;
            period_q    <= '0;
            lag_out_q   <= '0;
            lag_valid_q <= 1'b0;
            rv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lag_q       <= lag_d;
            b_seen_q    <= b_seen_d;
            miss_q      <= miss_d;
            idx_q       <= idx_d;
            psum_q      <= psum_d;
            lsum_q      <= lsum_d;
            period_q    <= period_d;
            lag_out_q   <= lag_out_d;
            lag_valid_q <= lag_valid_d;
            rv_q        <= rv_d;
        end
    end

    assign period_out   = period_q;
    assign lag_out      = lag_out_q;
    assign lag_valid    = lag_valid_q;
    assign result_valid = rv_q;
    // FAULT is only reachable through a timeout, and leaving it means IDLE.
    assign timeout      = (state_q == S_FAULT);
    assign busy         = (state_q == S_ARM) || (state_q == S_MEASURE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_clk_phase_meter.sv
`timescale 1ns/1ps
module tb_clk_phase_meter;

  localparam int W  = 16;
  localparam int W8 = 8;
  localparam int NONE = 9;  // miss_idx value meaning "sig_b present in every period"

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, enable, sig_a, sig_b;
  logic [W-1:0] period_out, lag_out;
  logic result_valid, lag_valid, timeout, busy;
  logic [1:0] dbg_state;

  logic en8, a8, b8;
  logic [W8-1:0] period8, lag8;
  logic rv8, lv8, to8, busy8;
  logic [1:0] dbg8;

  clk_phase_meter #(.CNT_W(W), .AVG_LOG2(2), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_a(sig_a), .sig_b(sig_b),
    .period_out(period_out), .lag_out(lag_out), .result_valid(result_valid),
    .lag_valid(lag_valid), .timeout(timeout), .busy(busy), .dbg_state(dbg_state)
  );

  clk_phase_meter #(.CNT_W(W8), .AVG_LOG2(2), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .enable(en8), .sig_a(a8), .sig_b(b8),
    .period_out(period8), .lag_out(lag8), .result_valid(rv8),
    .lag_valid(lv8), .timeout(to8), .busy(busy8), .dbg_state(dbg8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rv8_cnt = 0;
  logic [2*W:0] exp_q[$];   // {period, lag, lag_valid}
  int rv_cyc[$];
  logic [2*W:0] last_exp;
  logic [2*W:0] mon_e;

  typedef struct {
    logic [3:0][7:0] p;
    int lag;
    int miss_idx;
    int e_per;
    int e_lag;
    bit e_lv;
  } win_t;

  win_t tbl[7];

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic win_t mk(input int p0, input int p1, input int p2, input int p3,
                              input int lag, input int miss, input int per,
                              input int lg, input bit lv);
    win_t w;
    w.p[0] = 8'(p0); w.p[1] = 8'(p1); w.p[2] = 8'(p2); w.p[3] = 8'(p3);
    w.lag = lag; w.miss_idx = miss; w.e_per = per; w.e_lag = lg; w.e_lv = lv;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rv8) rv8_cnt <= rv8_cnt + 1;

  // Result monitor: every strobe must match the oldest expected window.
  always @(negedge clk) begin
    if (result_valid) begin
      rv_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period_out", period_out, mon_e[2*W:W+1]);
        check("lag_valid", lag_valid, mon_e[0]);
        if (mon_e[0]) check("lag_out", lag_out, mon_e[W:1]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_period(input int p, input int lag, input bit b_on);
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      sig_a = (c < p / 2);
      sig_b = b_on && (c >= lag) && (c < lag + p / 2);
    end
  endtask

  // Expectation is queued once the window's four periods are driven; the
  // closing edge is the first rise of whatever is driven next.
  task automatic drive_window(input win_t w, input bit push);
    for (int k = 0; k < 4; k++) drive_period(int'(w.p[k]), w.lag, w.miss_idx != k);
    if (push) begin
      last_exp = {16'(w.e_per), 16'(w.e_lag), w.e_lv};
      exp_q.push_back(last_exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int busy_cnt;
    int sum;
    int pr[4];
    int lg;
    bit seen;

    tbl[0] = mk(10, 10, 10, 10, 3, NONE, 10, 3, 1);
    tbl[1] = mk(10, 10, 10, 10, 3, NONE, 10, 3, 1);
    tbl[2] = mk( 9,  9,  9, 10, 0, NONE,  9, 0, 1);
    tbl[3] = mk(10, 10, 10, 10, 0, NONE, 10, 0, 1);
    tbl[4] = mk(10, 10, 10, 10, 2, 1,    10, 1, 0);
    tbl[5] = mk(10, 10, 10, 10, 2, NONE, 10, 2, 1);
    tbl[6] = mk(12, 13, 11,  9, 2, NONE, 11, 2, 1);

    reset_n = 1'b0; enable = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    en8 = 1'b0; a8 = 1'b0; b8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_period_out", period_out, 0);
    check("rst_lag_out", lag_out, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_lag_valid", lag_valid, 0);
    check("rst_timeout", timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst8_period_out", period8, 0);
    check("rst8_timeout", to8, 0);
    check("rst8_busy", busy8, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Sequence 1: back-to-back windows from the table plus two random ones
    enable = 1'b1;
    idle(4);
    check("arm_busy", busy, 1);
    for (int i = 0; i < 7; i++) drive_window(tbl[i], 1'b1);
    for (int r = 0; r < 2; r++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        pr[k] = $urandom_range(6, 20);
        sum += pr[k];
      end
      lg = $urandom_range(0, 2);
      drive_window(mk(pr[0], pr[1], pr[2], pr[3], lg, NONE, sum >> 2, lg, 1), 1'b1);
    end
    drive_period(10, 3, 1'b1);
    idle(6);
    check("seq1_drained", exp_q.size(), 0);
    if (rv_cyc.size() >= 2) check("result_spacing", rv_cyc[1] - rv_cyc[0], 40);
    else check("result_count", rv_cyc.size(), 9);
    enable = 1'b0;
    idle(3);

    // Sequence 2: abort after two closed periods, then a clean window
    enable = 1'b1;
    idle(4);
    drive_period(10, 3, 1'b1);
    drive_period(10, 3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sig_a = 1'b1;
      sig_b = 1'b0;
    end
    @(negedge clk);
    enable = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_period_held", period_out, last_exp[2*W:W+1]);
    check("abort_lag_held", lag_out, last_exp[W:1]);
    check("abort_lag_valid_held", lag_valid, last_exp[0]);
    idle(10);
    check("abort_period_still", period_out, last_exp[2*W:W+1]);
    enable = 1'b1;
    idle(4);
    check("rearm_busy", busy, 1);
    drive_window(mk(10, 10, 10, 10, 4, NONE, 10, 4, 1), 1'b1);
    drive_period(10, 4, 1'b1);
    idle(6);
    check("seq2_drained", exp_q.size(), 0);

    // Sequence 3: reset pulse mid-window while enable stays high
    drive_period(10, 2, 1'b1);
    drive_period(10, 2, 1'b1);
    drive_period(10, 2, 1'b1);
    @(negedge clk);
    reset_n = 1'b0; sig_a = 1'b0; sig_b = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_period_out", period_out, 0);
    check("mid_rst_lag_out", lag_out, 0);
    check("mid_rst_lag_valid", lag_valid, 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", timeout, 0);
    idle(5);
    drive_window(mk(12, 12, 12, 12, 1, NONE, 12, 1, 1), 1'b1);
    drive_period(12, 1, 1'b1);
    idle(6);
    check("seq3_drained", exp_q.size(), 0);
    enable = 1'b0;
    idle(3);

    // Sequence 4: timeout on the 8-bit instance with sig_a stuck low
    en8 = 1'b1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (to8) seen = 1'b1;
      else if (busy8) busy_cnt++;
    end
    check("timeout_seen", to8, 1);
    check("timeout_arm_cycles", busy_cnt, 255);
    check("fault_busy", busy8, 0);
    check("fault_state", dbg8, 3);
    repeat (5) @(negedge clk);
    check("timeout_sticky", to8, 1);
    en8 = 1'b0;
    @(negedge clk);
    check("timeout_cleared", to8, 0);
    check("idle8_busy", busy8, 0);
    en8 = 1'b1;
    @(negedge clk);
    check("rearm8_busy", busy8, 1);
    en8 = 1'b0;
    repeat (3) @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    check("dut8_no_results", rv8_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
